// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared widths, reset address and the fetch queue entry type
package fetch_unit_pkg;
  localparam int DATA_W = 16;
  localparam int ROM_ADDR_W_DEF = 15;
  localparam logic [DATA_W-1:0] PC_RESET_ADDR = '0;
  typedef struct packed {
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: pc control, ROM, redirect and decode handshake signals of the fetch stage
interface fetch_unit_if
  import fetch_unit_pkg::*;
#(
  parameter int ROM_ADDR_W = ROM_ADDR_W_DEF
);
  logic [DATA_W-1:0] pc;
  logic pc_inc;
  logic pc_load;
  logic [DATA_W-1:0] pc_target;
  logic rom_en;
  logic [ROM_ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic redirect;
  logic [DATA_W-1:0] redirect_addr;
  logic instr_valid;
  logic instr_ready;
  logic [DATA_W-1:0] instr;
  logic [DATA_W-1:0] instr_pc;
  modport master (
    input pc, rom_data, redirect, redirect_addr, instr_ready,
    output pc_inc, pc_load, pc_target, rom_en, rom_addr, instr_valid, instr, instr_pc
  );
  modport slave (
    output pc, rom_data, redirect, redirect_addr, instr_ready,
    input pc_inc, pc_load, pc_target, rom_en, rom_addr, instr_valid, instr, instr_pc
  );
endinterface

// File: rtl/fetch_unit_fifo.sv
// fetch_fifo: synchronous FIFO for fetched {pc, instr} pairs; flush wins over push
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [AW:0]      count,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full
);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr, rd;
  logic do_push, do_pop;
  assign empty = count == '0;
  assign full = count == CW'(DEPTH);
  assign do_pop = pop & !empty;
  assign do_push = push & (!full | do_pop);
  assign head = mem[rd];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr <= '0;
      rd <= '0;
      count <= '0;
    end else if (flush) begin
      wr <= '0;
      rd <= '0;
      count <= '0;
    end else begin
      wr <= wr + AW'(do_push);
      rd <= rd + AW'(do_pop);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push & !flush) mem[wr] <= din;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: credit-based instruction fetch between pc, a synchronous ROM and decode
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int ROM_ADDR_W = ROM_ADDR_W_DEF
) (
  input logic clk,
  input logic rst,
  fetch_unit_if.master bus
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  fetch_entry_t head;
  logic [CW-1:0] count;
  logic [DATA_W-1:0] tag;
  logic empty, full, inflight, kill, resp, pop, issue;
  assign resp = inflight & !kill;
  assign pop = !empty & bus.instr_ready;
  // a slot is reserved for every read still in flight, so a push never meets a full queue
  assign issue = !rst & !bus.redirect & !full & (count + CW'(resp) < CW'(FIFO_DEPTH) + CW'(pop));
  assign bus.rom_en = issue;
  assign bus.pc_inc = issue;
  assign bus.rom_addr = issue ? bus.pc[ROM_ADDR_W-1:0] : '0;
  assign bus.pc_load = !rst & bus.redirect;
  assign bus.pc_target = bus.pc_load ? bus.redirect_addr : '0;
  assign bus.instr_valid = !empty;
  assign bus.instr = empty ? '0 : head.instr;
  assign bus.instr_pc = empty ? '0 : head.pc;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      inflight <= 1'b0;
      kill <= 1'b0;
      tag <= '0;
    end else begin
      inflight <= issue;
      kill <= bus.redirect;
      if (issue) tag <= bus.pc;
    end
  fetch_fifo #(.WIDTH(2 * DATA_W), .DEPTH(FIFO_DEPTH)) u_fetch_fifo (
    .clk(clk),
    .rst(rst),
    .push(resp),
    .pop(pop),
    .flush(bus.redirect),
    .din({tag, bus.rom_data}),
    .count(count),
    .head(head),
    .empty(empty),
    .full(full)
  );
  a_inc_load: assert property (@(posedge clk) disable iff (rst) !(bus.pc_inc && bus.pc_load));
  a_count: assert property (@(posedge clk) disable iff (rst) count <= CW'(FIFO_DEPTH));
  a_full_en: assert property (@(posedge clk) disable iff (rst) !(full && bus.rom_en));
endmodule
